ps2_key_event_ctrl: RTL and testbench

//  Sequences the raw PS/2 byte stream (received_data / received_data_en of PS2_Controller)

---
 rtl/ps2_key_event_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_key_event_ctrl: PS/2 byte stream -> {ext,brk,code} key-event FIFO      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH   = 8,
  parameter bit SUPPRESS_REP = 1'b1
) (
  input  logic                         CLOCK_50,
  input  logic                         Reset,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_en,
  input  logic                         evt_ready,
  output logic                         evt_valid,
  output logic [7:0]                   evt_code,
  output logic                         evt_ext,
  output logic                         evt_break,
  output logic [3:0]                   key_held,
  output logic [$clog2(FIFO_DEPTH):0]  evt_count,
  output logic                         overflow
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_full    = (c_aw+1)'(FIFO_DEPTH);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  state_t          r_state, w_nxt_state;
  logic [2:0]      r_skip_cnt, w_nxt_cnt;
  logic            w_emit, w_ext, w_brk, w_status, w_fake_shift;
  logic [8:0]      w_key, r_last_make;
  logic [3:0]      w_hit;
  logic            w_supp, w_push, w_pop, w_full, w_wr;
  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [9:0]      w_head;
  logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]   r_count;

  assign w_status = rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  assign w_fake_shift = (rx_data == 8'h12) || (rx_data == 8'h59);

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_skip_cnt <= 3'd0;
    end else begin
      r_state    <= w_nxt_state;
      r_skip_cnt <= w_nxt_cnt;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_skip_cnt;
    w_emit      = 1'b0;
    w_ext       = 1'b0;
    w_brk       = 1'b0;
    if (rx_en) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == 8'hE0)      w_nxt_state = S_EXT;
          else if (rx_data == 8'hF0) w_nxt_state = S_BRK;
          else if (rx_data == 8'hE1) begin
            w_nxt_state = S_SKIP;
            w_nxt_cnt   = 3'd7;
          end else if (!w_status)    w_emit = 1'b1;
        end
        S_EXT: begin
          w_nxt_state = S_IDLE;
          if (rx_data == 8'hF0) w_nxt_state = S_EXT_BRK;
          else if (!w_fake_shift) begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
          end
        end
        S_BRK, S_EXT_BRK: begin
          // A prefix here restarts decoding rather than completing the release
          w_nxt_state = S_IDLE;
          if (rx_data == 8'hE0)      w_nxt_state = S_EXT;
          else if (rx_data == 8'hF0) w_nxt_state = S_BRK;
          else if (r_state == S_BRK) begin
            w_emit = 1'b1;
            w_brk  = 1'b1;
          end else if (!w_fake_shift) begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_brk  = 1'b1;
          end
        end
        S_SKIP: begin
          if (r_skip_cnt <= 3'd1) begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = 3'd0;
          end else begin
            w_nxt_cnt = r_skip_cnt - 3'd1;
          end
        end
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  assign w_key    = {w_ext, rx_data};
  assign w_supp   = SUPPRESS_REP && w_emit && !w_brk && (w_key == r_last_make);
  assign w_hit[0] = (w_key == 9'h16B);
  assign w_hit[1] = (w_key == 9'h174);
  assign w_hit[2] = (w_key == 9'h029);
  assign w_hit[3] = (w_key == 9'h05A);

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_last_make <= 9'd0;
      key_held    <= 4'd0;
    end else if (w_emit) begin
      if (!w_brk && !w_supp)                    r_last_make <= w_key;
      else if (w_brk && w_key == r_last_make)   r_last_make <= 9'd0;
      for (int i = 0; i < 4; i++)
        if (w_hit[i]) key_held[i] <= !w_brk;
    end
  end

  // Write is allowed when full only if the head leaves in the same cycle
  assign w_push = w_emit && !w_supp;
  assign w_pop  = evt_valid && evt_ready;
  assign w_full = (r_count == c_full);
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      if (w_push && w_full && !w_pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_ext, w_brk, rx_data};
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign evt_valid = (r_count != '0);
  assign evt_count = r_count;
  assign evt_code  = evt_valid ? w_head[7:0] : 8'd0;
  assign evt_ext   = evt_valid & w_head[9];
  assign evt_break = evt_valid & w_head[8];

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ps2_key_event_ctrl: random + directed byte streams vs. sequence model   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ps2_key_event_ctrl;
  localparam int DEPTH = 8;

  logic       CLOCK_50 = 1'b0;
  logic       Reset, rx_en, evt_ready;
  logic [7:0] rx_data;
  logic       evt_valid, evt_ext, evt_break, overflow;
  logic [7:0] evt_code;
  logic [3:0] key_held, evt_count;

  ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .SUPPRESS_REP(1'b1)) dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .rx_data(rx_data), .rx_en(rx_en),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .key_held(key_held),
    .evt_count(evt_count), .overflow(overflow));

  always #10 CLOCK_50 = ~CLOCK_50;

  int         n_cmp = 0, n_bad = 0;
  bit         started = 0;
  logic [7:0] pend[$];      // prefix bytes seen since the last complete sequence
  logic [9:0] m_q[$];       // expected FIFO contents {ext,brk,code}
  logic [8:0] last_make;
  logic [3:0] m_held;
  logic       m_ovf;
  logic [8:0] game_key [4];
  logic [7:0] keys [4];
  logic [7:0] stat [8];

  initial begin
    game_key[0] = 9'h16B; game_key[1] = 9'h174; game_key[2] = 9'h029; game_key[3] = 9'h05A;
    keys[0] = 8'h6B; keys[1] = 8'h74; keys[2] = 8'h29; keys[3] = 8'h5A;
    stat[0] = 8'h00; stat[1] = 8'hAA; stat[2] = 8'hEE; stat[3] = 8'hFA;
    stat[4] = 8'hFC; stat[5] = 8'hFD; stat[6] = 8'hFE; stat[7] = 8'hFF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_status(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  endfunction

  task automatic model_byte(input logic [7:0] b);
    bit emit = 0, ext = 0, brk = 0;
    logic [8:0] key;
    if (pend.size() != 0 && pend[0] == 8'hE1) begin
      pend.push_back(b);                       // Pause: E1 plus seven bytes
      if (pend.size() == 8) pend.delete();
    end else begin
      ext = (pend.size() != 0 && pend[0] == 8'hE0);
      brk = (pend.size() != 0 && pend[pend.size()-1] == 8'hF0);
      if (b == 8'hF0) begin
        if (ext && !brk) pend.push_back(b);
        else begin pend.delete(); pend.push_back(b); end
      end else if (b == 8'hE0 && !(ext && !brk)) begin
        pend.delete(); pend.push_back(b);
      end else if (b == 8'hE1 && pend.size() == 0) pend.push_back(b);
      else if (pend.size() == 0 && is_status(b)) begin end
      else if (ext && (b == 8'h12 || b == 8'h59)) pend.delete();
      else begin emit = 1; pend.delete(); end
    end
    if (emit) begin
      key = {ext, b};
      for (int i = 0; i < 4; i++) if (key == game_key[i]) m_held[i] = !brk;
      if (!brk && key == last_make) return;    // typematic repeat
      if (!brk) last_make = key;
      else if (key == last_make) last_make = 9'd0;
      if (m_q.size() == DEPTH) m_ovf = 1'b1;
      else m_q.push_back({ext, brk, b});
    end
  endtask

  always @(posedge CLOCK_50) begin
    if (Reset) begin
      started = 1; pend.delete(); m_q.delete();
      last_make = 0; m_held = 0; m_ovf = 0;
    end else if (rx_en) model_byte(rx_data);
  end

  always @(negedge CLOCK_50) begin
    if (started) begin
      chk("evt_valid", evt_valid, m_q.size() != 0);
      chk("evt_count", evt_count, m_q.size());
      chk("key_held", key_held, m_held);
      chk("overflow", overflow, m_ovf);
      if (m_q.size() != 0) begin
        chk("evt_head", {evt_ext, evt_break, evt_code}, m_q[0]);
        if (evt_ready) void'(m_q.pop_front());
      end else if (Reset) begin
        chk("reset_head_zero", {evt_ext, evt_break, evt_code}, 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLOCK_50); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_en = 1'b1;
    @(posedge CLOCK_50); #1;
    rx_en = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  function automatic logic [7:0] pick();
    int r = $urandom_range(0, 15);
    if (r < 2)       return 8'hE0;
    else if (r < 4)  return 8'hF0;
    else if (r == 4) return ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1C;
    else if (r == 5) return stat[$urandom_range(0, 7)];
    else if (r == 6) return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
    else if (r < 12) return keys[$urandom_range(0, 3)];
    else             return 8'($urandom);
  endfunction

  initial begin
    int guard;
    Reset = 1'b1; rx_en = 1'b0; rx_data = 8'h00; evt_ready = 1'b0;
    idle(2);
    Reset = 1'b0;
    send(8'h1C); idle(1);
    evt_ready = 1'b1; idle(2);
    send_seq('{8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h6B}); idle(2);
    send_seq('{8'h29, 8'h29, 8'h29, 8'hF0, 8'h29}); idle(2);
    evt_ready = 1'b0;
    send_seq('{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44}); idle(1);
    evt_ready = 1'b1;
    send(8'h4D); idle(10);
    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C, 8'hAA, 8'hFA});
    idle(3);
    send(8'hE0);
    Reset = 1'b1; idle(2); Reset = 1'b0;
    send(8'h6B); idle(3);
    for (int i = 0; i < 3000; i++) begin
      evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      if (i == 1500) begin Reset = 1'b1; idle(1); Reset = 1'b0; end
      send(pick());
    end
    evt_ready = 1'b1;
    guard = 0;
    while (m_q.size() != 0 && guard < 50) begin idle(1); guard++; end
    chk("drain_timeout", m_q.size(), 0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
